l2_stream_pointer: RTL and testbench

// - Per-stream pointer/credit controller for one L2 stream buffer of l2_ncl 128 B lines held in URAM.
// - After a functional reset with byte range [ea_b, ea_e), it issues OpenCAPI 3.0 line requests and counts the in-order responses.
// - It serves L1 line reads as URAM read pointers and signals reset acceptance and end-of-stream.
// - It only tracks counts and pointers; request address generation and data movement are external.

---
 rtl/l2_stream_pointer.sv | 153 +++++++++++++++
 tb/tb_l2_stream_pointer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_stream_pointer.sv
// Pointer/credit controller for one L2 stream buffer of l2_ncl lines.
// Optional simulation checks are enabled by defining L2_STREAM_PTR_ASSERT_EN.
module l2_stream_pointer #(
  parameter int unsigned addr_width   = 64,
  parameter int unsigned l2_ncl       = 256,
  parameter int unsigned l2_ncl_width = $clog2(l2_ncl),
  parameter int unsigned cl_bytes     = 128
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_rst_v,
  output logic                    i_rst_r,
  input  logic [addr_width-1:0]   i_rst_ea_b,
  input  logic [addr_width-1:0]   i_rst_ea_e,
  output logic                    o_rst_v,
  input  logic                    o_rst_r,
  output logic                    o_rst_end,
  input  logic                    i_rd_v,
  output logic                    i_rd_r,
  output logic                    o_addr_v,
  input  logic                    o_addr_r,
  output logic [l2_ncl_width-1:0] o_addr_ptr,
  output logic                    o_req_v,
  input  logic                    o_req_r,
  input  logic                    i_rsp_v,
  output logic                    i_rsp_r
);

  localparam int unsigned cl_shift = $clog2(cl_bytes);
  localparam int unsigned cnt_w    = addr_width - cl_shift;

  typedef logic [cnt_w-1:0] cnt_t;

  localparam cnt_t ncl_lines = cnt_t'(l2_ncl);

  cnt_t                    total;
  cnt_t                    issued;
  cnt_t                    received;
  cnt_t                    consumed;
  logic [l2_ncl_width-1:0] wr_ptr;
  logic [l2_ncl_width-1:0] rd_ptr;
  logic                    active;

  cnt_t line_b;
  cnt_t line_e;
  cnt_t in_flight;
  logic avail;
  logic done;
  logic rst_acc;
  logic rd_acc;
  logic req_acc;
  logic rsp_acc;

  assign line_b    = cnt_t'(i_rst_ea_b >> cl_shift);
  assign line_e    = cnt_t'(i_rst_ea_e >> cl_shift);
  assign in_flight = issued - consumed;
  assign avail     = received > consumed;
  assign done      = consumed == total;

  assign i_rst_r = (issued == received) & ~o_rst_v;
  assign i_rd_r  = active & ~i_rst_v & ~o_addr_v & ~o_rst_v & (avail | done);
  assign o_req_v = active & (issued < total) & (in_flight < ncl_lines);
  assign i_rsp_r = 1'b1;

  assign rst_acc = i_rst_v & i_rst_r;
  assign rd_acc  = i_rd_v & i_rd_r;
  assign req_acc = o_req_v & o_req_r;
  // Responses with nothing outstanding are stray and must not move the counters.
  assign rsp_acc = i_rsp_v & (issued != received);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      total      <= '0;
      issued     <= '0;
      received   <= '0;
      consumed   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      active     <= 1'b0;
      o_rst_v    <= 1'b0;
      o_rst_end  <= 1'b0;
      o_addr_v   <= 1'b0;
      o_addr_ptr <= '0;
    end else begin
      if (rst_acc) begin
        total    <= (line_e > line_b) ? (line_e - line_b) : '0;
        issued   <= '0;
        received <= '0;
        consumed <= '0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        active   <= 1'b1;
      end else begin
        if (req_acc) issued <= issued + cnt_t'(1);
        if (rsp_acc) begin
          received <= received + cnt_t'(1);
          wr_ptr   <= wr_ptr + 1'b1;
        end
        if (rd_acc && avail) begin
          consumed <= consumed + cnt_t'(1);
          rd_ptr   <= rd_ptr + 1'b1;
        end
      end

      // A read that finds nothing buffered can only mean the stream is finished.
      if (rst_acc) begin
        o_rst_v   <= 1'b1;
        o_rst_end <= 1'b0;
      end else if (rd_acc && !avail) begin
        o_rst_v   <= 1'b1;
        o_rst_end <= 1'b1;
      end else if (o_rst_r) begin
        o_rst_v   <= 1'b0;
      end

      if (rd_acc && avail) begin
        o_addr_v   <= 1'b1;
        o_addr_ptr <= rd_ptr;
      end else if (o_addr_r) begin
        o_addr_v   <= 1'b0;
      end
    end
  end

`ifdef L2_STREAM_PTR_ASSERT_EN
  logic                    addr_stall_q;
  logic [l2_ncl_width-1:0] addr_ptr_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_stall_q <= 1'b0;
      addr_ptr_q   <= '0;
    end else begin
      addr_stall_q <= o_addr_v & ~o_addr_r;
      addr_ptr_q   <= o_addr_ptr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      if (i_rsp_v && (issued == received))
        $error("l2_stream_pointer: response with nothing outstanding");
      if (in_flight > ncl_lines)
        $error("l2_stream_pointer: occupancy above l2_ncl");
      if (!((consumed <= received) && (received <= issued) && (issued <= total)))
        $error("l2_stream_pointer: counter ordering broken");
      if (addr_stall_q && (o_addr_ptr != addr_ptr_q))
        $error("l2_stream_pointer: o_addr_ptr moved while stalled");
    end
  end
`endif

endmodule

// File: tb/tb_l2_stream_pointer.sv
// Directed bench for l2_stream_pointer: requests looped back as responses one cycle later.
module tb_l2_stream_pointer;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_rst_v;
  logic        i_rst_r;
  logic [63:0] ea_b;
  logic [63:0] ea_e;
  logic        o_rst_v;
  logic        o_rst_r;
  logic        o_rst_end;
  logic        i_rd_v;
  logic        i_rd_r;
  logic        o_addr_v;
  logic        o_addr_r;
  logic [7:0]  o_addr_ptr;
  logic        o_req_v;
  logic        o_req_r;
  logic        i_rsp_v;
  logic        i_rsp_r;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  int req_tot     = 0;
  int rst_ok_tot  = 0;
  int rst_end_tot = 0;

  l2_stream_pointer dut (
    .clk        (clk),
    .reset      (reset),
    .i_rst_v    (i_rst_v),
    .i_rst_r    (i_rst_r),
    .i_rst_ea_b (ea_b),
    .i_rst_ea_e (ea_e),
    .o_rst_v    (o_rst_v),
    .o_rst_r    (o_rst_r),
    .o_rst_end  (o_rst_end),
    .i_rd_v     (i_rd_v),
    .i_rd_r     (i_rd_r),
    .o_addr_v   (o_addr_v),
    .o_addr_r   (o_addr_r),
    .o_addr_ptr (o_addr_ptr),
    .o_req_v    (o_req_v),
    .o_req_r    (o_req_r),
    .i_rsp_v    (i_rsp_v),
    .i_rsp_r    (i_rsp_r)
  );

  always #5 clk = ~clk;

  // One-register loopback: each request handshake returns as a response next cycle.
  always @(posedge clk or negedge reset) begin
    if (!reset) i_rsp_v <= 1'b0;
    else        i_rsp_v <= o_req_v & o_req_r;
  end

  // Handshakes seen at the falling edge complete at the following rising edge.
  always @(negedge clk) begin
    if (reset) begin
      if (o_req_v && o_req_r) req_tot++;
      if (o_rst_v && o_rst_r) begin
        if (o_rst_end) rst_end_tot++;
        else           rst_ok_tot++;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tmo_fail(input string tag);
    n_chk++;
    n_fail++;
    $error("FAIL %s: wait budget expired", tag);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_frst(input logic [63:0] b, input logic [63:0] e);
    int t;
    t = 0;
    while (!i_rst_r && t < 2000) begin step(); t++; end
    if (t >= 2000) tmo_fail("frst_wait");
    ea_b = b;
    ea_e = e;
    i_rst_v = 1'b1;
    step();
    i_rst_v = 1'b0;
    check("frst_ack_v", 64'(o_rst_v), 64'd1);
    check("frst_ack_end", 64'(o_rst_end), 64'd0);
    step();
  endtask

  task automatic do_read(output logic a_v, output logic [7:0] p,
                         output logic e_v, output logic e_end);
    int t;
    t = 0;
    i_rd_v = 1'b1;
    while (!i_rd_r && t < 2000) begin step(); t++; end
    if (t >= 2000) tmo_fail("rd_wait");
    step();
    i_rd_v = 1'b0;
    a_v   = o_addr_v;
    p     = o_addr_ptr;
    e_v   = o_rst_v;
    e_end = o_rst_end;
  endtask

  task automatic wait_reqs(input int base, input int n);
    int t;
    t = 0;
    while ((req_tot - base) < n && t < 3000) begin step(); t++; end
    if (t >= 3000) tmo_fail("req_wait");
    repeat (5) step();
  endtask

  initial begin
    logic       a_v;
    logic [7:0] p;
    logic       e_v;
    logic       e_end;
    int         base;
    int         base_ok;
    int         base_end;
    int         t;

    reset    = 1'b0;
    i_rst_v  = 1'b0;
    ea_b     = '0;
    ea_e     = '0;
    i_rd_v   = 1'b0;
    o_rst_r  = 1'b1;
    o_addr_r = 1'b1;
    o_req_r  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_o_rst_v", 64'(o_rst_v), 64'd0);
    check("rst_o_rst_end", 64'(o_rst_end), 64'd0);
    check("rst_o_addr_v", 64'(o_addr_v), 64'd0);
    check("rst_o_addr_ptr", 64'(o_addr_ptr), 64'd0);
    check("rst_o_req_v", 64'(o_req_v), 64'd0);
    check("rst_i_rsp_r", 64'(i_rsp_r), 64'd1);
    check("rst_i_rst_r", 64'(i_rst_r), 64'd1);
    check("rst_i_rd_r", 64'(i_rd_r), 64'd0);
    reset = 1'b1;
    step();

    // Stream of 256 lines; a second reset attempted mid-flight must be dropped.
    base    = req_tot;
    base_ok = rst_ok_tot;
    do_frst(64'd32768, 64'd65536);
    check("s1_req_v_on", 64'(o_req_v), 64'd1);
    repeat (8) step();
    check("s3_rst_r_busy", 64'(i_rst_r), 64'd0);
    ea_b = 64'd384;
    ea_e = 64'd38400;
    i_rst_v = 1'b1;
    step();
    i_rst_v = 1'b0;
    check("s3_dropped", 64'(o_rst_v), 64'd0);
    wait_reqs(base, 256);
    check("s1_req_cnt", 64'(req_tot - base), 64'd256);
    check("s1_req_idle", 64'(o_req_v), 64'd0);
    check("s1_one_ack", 64'(rst_ok_tot - base_ok), 64'd1);
    check("s1_rsp_done", 64'(i_rst_r), 64'd1);

    do_read(a_v, p, e_v, e_end);
    check("s2_rd0", {a_v, p, e_v}, {1'b1, 8'd0, 1'b0});
    do_read(a_v, p, e_v, e_end);
    check("s2_rd1", {a_v, p, e_v}, {1'b1, 8'd1, 1'b0});
    check("s2_no_more_req", 64'(o_req_v), 64'd0);
    for (int k = 2; k < 256; k++) begin
      do_read(a_v, p, e_v, e_end);
      check("s2_drain_ptr", {a_v, p}, {1'b1, 8'(k)});
    end
    base_end = rst_end_tot;
    do_read(a_v, p, e_v, e_end);
    check("s5a_end", {a_v, e_v, e_end}, {1'b0, 1'b1, 1'b1});
    check("s3_total_kept", 64'(req_tot - base), 64'd256);

    // 508-line stream: occupancy caps requests at 256 until reads free space.
    base = req_tot;
    do_frst(64'd512, 64'd65536);
    check("s5a_end_cnt", 64'(rst_end_tot - base_end), 64'd1);
    wait_reqs(base, 256);
    check("s4_req_cap", 64'(req_tot - base), 64'd256);
    check("s4_req_stall", 64'(o_req_v), 64'd0);
    for (int k = 0; k < 508; k++) begin
      do_read(a_v, p, e_v, e_end);
      check("s4_rd_ptr", {a_v, p}, {1'b1, 8'(k)});
    end
    repeat (5) step();
    check("s4_req_total", 64'(req_tot - base), 64'd508);
    check("s4_req_idle", 64'(o_req_v), 64'd0);
    do_read(a_v, p, e_v, e_end);
    check("s5_end", {a_v, e_v, e_end}, {1'b0, 1'b1, 1'b1});

    // Empty range: no requests, first read ends the stream.
    do_frst(64'd200, 64'd100);
    check("z_req_v", 64'(o_req_v), 64'd0);
    do_read(a_v, p, e_v, e_end);
    check("z_end", {a_v, e_v, e_end}, {1'b0, 1'b1, 1'b1});

    // Hard reset in the middle of a stream with a stalled URAM read.
    do_frst(64'd0, 64'd65536);
    repeat (20) step();
    check("s6_req_v_pre", 64'(o_req_v), 64'd1);
    o_addr_r = 1'b0;
    i_rd_v = 1'b1;
    t = 0;
    while (!i_rd_r && t < 100) begin step(); t++; end
    if (t >= 100) tmo_fail("s6_rd_wait");
    step();
    i_rd_v = 1'b0;
    check("s6_addr_pre", {o_addr_v, o_addr_ptr}, {1'b1, 8'd0});
    step();
    check("s6_addr_hold", {o_addr_v, o_addr_ptr}, {1'b1, 8'd0});
    reset = 1'b0;
    step();
    check("s6_o_rst_v", 64'(o_rst_v), 64'd0);
    check("s6_o_rst_end", 64'(o_rst_end), 64'd0);
    check("s6_o_addr_v", 64'(o_addr_v), 64'd0);
    check("s6_o_addr_ptr", 64'(o_addr_ptr), 64'd0);
    check("s6_o_req_v", 64'(o_req_v), 64'd0);
    check("s6_i_rst_r", 64'(i_rst_r), 64'd1);
    check("s6_i_rd_r", 64'(i_rd_r), 64'd0);
    check("s6_i_rsp_r", 64'(i_rsp_r), 64'd1);
    o_addr_r = 1'b1;
    reset = 1'b1;
    step();
    check("s6_inactive_req", 64'(o_req_v), 64'd0);
    check("s6_inactive_rd", 64'(i_rd_r), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
